// File: rtl/regfile_sb.sv
// Multi-port register file with write-through bypass and a per-register
// pending scoreboard used by issue logic for RAW stall detection.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 4,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic [NUM_WR-1:0]        iss_en,
  input  logic [NUM_WR*ADDR_W-1:0] iss_addr,
  input  logic                     flush,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam int NREG = 2**ADDR_W;

  logic [DATA_W-1:0] mem_reg [NREG];
  logic [NREG-1:0]   pending_reg;

  // Later ports overwrite earlier ones in the loop, so the highest index wins a WAW.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        mem_reg[r] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (we[k] && (waddr[k*ADDR_W +: ADDR_W] != '0)) begin
          mem_reg[waddr[k*ADDR_W +: ADDR_W]] <= wdata[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign pending_reg[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_sb
      logic iss_hit;
      logic wr_hit;
      logic pend_reg;

      always_comb begin
        iss_hit = 1'b0;
        wr_hit  = 1'b0;
        for (int k = 0; k < NUM_WR; k++) begin
          if (iss_en[k] && (iss_addr[k*ADDR_W +: ADDR_W] == ADDR_W'(gi))) iss_hit = 1'b1;
          if (we[k] && (waddr[k*ADDR_W +: ADDR_W] == ADDR_W'(gi)))        wr_hit  = 1'b1;
        end
      end

      // An issue is always younger than a same-cycle writeback or flush, so it sets.
      always_ff @(posedge clk) begin
        if (rst) begin
          pend_reg <= 1'b0;
        end else if (flush) begin
          pend_reg <= iss_hit;
        end else if (iss_hit) begin
          pend_reg <= 1'b1;
        end else if (wr_hit) begin
          pend_reg <= 1'b0;
        end
      end

      assign pending_reg[gi] = pend_reg;
    end

    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] lane_data;
      logic              lane_busy;
      logic              byp;

      assign ra = raddr[gi*ADDR_W +: ADDR_W];

      always_comb begin
        lane_data = mem_reg[ra];
        byp       = 1'b0;
        for (int k = 0; k < NUM_WR; k++) begin
          if (we[k] && (waddr[k*ADDR_W +: ADDR_W] == ra)) begin
            byp       = 1'b1;
            lane_data = wdata[k*DATA_W +: DATA_W];
          end
        end
        lane_busy = pending_reg[ra] & ~byp;
        if (rst || (ra == '0)) begin
          lane_data = '0;
          lane_busy = 1'b0;
        end
      end

      assign rdata[gi*DATA_W +: DATA_W] = lane_data;
      assign rbusy[gi]                  = lane_busy;
    end
  endgenerate

  assign dbg_data = (rst || (dbg_addr == '0)) ? '0 : mem_reg[dbg_addr];

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reset, WAW/bypass, r0, scoreboard set/clear/flush.
module tb_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;
  localparam int NW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NW-1:0]     we;
  logic [NW*AW-1:0]  waddr;
  logic [NW*DW-1:0]  wdata;
  logic [NR*AW-1:0]  raddr;
  logic [NR*DW-1:0]  rdata;
  logic [NR-1:0]     rbusy;
  logic [NW-1:0]     iss_en;
  logic [NW*AW-1:0]  iss_addr;
  logic              flush;
  logic [AW-1:0]     dbg_addr;
  logic [DW-1:0]     dbg_data;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .iss_en(iss_en),
    .iss_addr(iss_addr), .flush(flush), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = '0; waddr = '0; wdata = '0; iss_en = '0; iss_addr = '0; flush = 1'b0;
  endtask

  task automatic wr(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[k] = 1'b1;
    waddr[k*AW +: AW] = a;
    wdata[k*DW +: DW] = d;
  endtask

  task automatic iss(input int k, input logic [AW-1:0] a);
    iss_en[k] = 1'b1;
    iss_addr[k*AW +: AW] = a;
  endtask

  task automatic rd(input int i, input logic [AW-1:0] a);
    raddr[i*AW +: AW] = a;
  endtask

  initial begin
    rst = 1'b1; idle(); raddr = '0; dbg_addr = '0;
    step();

    // Test 1: preload reg5 (and mark it pending), then reset
    rst = 1'b0;
    wr(0, 5'd5, 32'hDEADBEEF); iss(1, 5'd5);
    step();
    idle(); dbg_addr = 5'd5; rd(0, 5'd5); #1;
    check("preload_dbg5", dbg_data, 32'hDEADBEEF);
    check("preload_busy5", 32'(rbusy[0]), 32'd1);
    rst = 1'b1; wr(0, 5'd5, 32'h00001234); #1;
    check("rst_rdata_bypass", rdata[0 +: DW], 32'h0);
    check("rst_rbusy", 32'(rbusy), 32'h0);
    check("rst_dbg", dbg_data, 32'h0);
    step();
    rst = 1'b0; idle(); #1;
    check("post_rst_dbg5", dbg_data, 32'h0);
    check("post_rst_busy5", 32'(rbusy[0]), 32'd0);

    // Test 2: WAW with bypass
    wr(0, 5'd7, 32'h11111111); wr(1, 5'd7, 32'h22222222);
    rd(0, 5'd7); rd(1, 5'd7); #1;
    check("waw_bypass_l0", rdata[0 +: DW], 32'h22222222);
    check("waw_bypass_l1", rdata[DW +: DW], 32'h22222222);
    step();
    idle(); dbg_addr = 5'd7; #1;
    check("waw_dbg7", dbg_data, 32'h22222222);
    check("waw_array_l0", rdata[0 +: DW], 32'h22222222);

    // Test 3: register 0 immunity
    wr(0, 5'd0, 32'hFFFFFFFF); iss(0, 5'd0); rd(0, 5'd0); #1;
    check("r0_rdata_same", rdata[0 +: DW], 32'h0);
    check("r0_busy_same", 32'(rbusy[0]), 32'd0);
    step();
    idle(); dbg_addr = 5'd0; #1;
    check("r0_rdata", rdata[0 +: DW], 32'h0);
    check("r0_busy", 32'(rbusy[0]), 32'd0);
    check("r0_dbg", dbg_data, 32'h0);

    // Test 4: scoreboard lifecycle on reg 9 (read on lane 2)
    iss(0, 5'd9); rd(2, 5'd9); #1;
    check("sb_t0_busy", 32'(rbusy[2]), 32'd0);
    step();
    idle(); #1;
    check("sb_t1_busy", 32'(rbusy[2]), 32'd1);
    check("sb_t1_data", rdata[2*DW +: DW], 32'h0);
    step(); #1;
    check("sb_t2_busy", 32'(rbusy[2]), 32'd1);
    step();
    wr(1, 5'd9, 32'hCAFE0001); #1;
    check("sb_t3_busy", 32'(rbusy[2]), 32'd0);
    check("sb_t3_bypass", rdata[2*DW +: DW], 32'hCAFE0001);
    step();
    idle(); #1;
    check("sb_t4_busy", 32'(rbusy[2]), 32'd0);
    check("sb_t4_data", rdata[2*DW +: DW], 32'hCAFE0001);

    // Test 5: set beats same-cycle clear on reg 12 (lane 3)
    iss(1, 5'd12); wr(0, 5'd12, 32'h00000005);
    step();
    idle(); rd(3, 5'd12); dbg_addr = 5'd12; #1;
    check("sbc_busy12", 32'(rbusy[3]), 32'd1);
    check("sbc_data12", rdata[3*DW +: DW], 32'h00000005);
    check("sbc_dbg12", dbg_data, 32'h00000005);

    // Test 6: flush with concurrent issue to 4
    iss(0, 5'd3); iss(1, 5'd4);
    step();
    idle(); iss(0, 5'd6);
    step();
    idle(); rd(0, 5'd3); rd(1, 5'd4); rd(2, 5'd6); #1;
    check("pre_flush_busy", 32'(rbusy), 32'h0000000F);
    flush = 1'b1; iss(0, 5'd4); #1;
    check("flush_cycle_busy", 32'(rbusy), 32'h0000000F);
    step();
    idle(); #1;
    check("post_flush_busy3", 32'(rbusy[0]), 32'd0);
    check("post_flush_busy4", 32'(rbusy[1]), 32'd1);
    check("post_flush_busy6", 32'(rbusy[2]), 32'd0);
    check("post_flush_busy12", 32'(rbusy[3]), 32'd0);

    // Write to a non-pending register clears nothing odd and leaves it idle
    wr(0, 5'd3, 32'h0BADF00D);
    step();
    idle(); #1;
    check("nonpend_wr_busy3", 32'(rbusy[0]), 32'd0);
    check("nonpend_wr_data3", rdata[0 +: DW], 32'h0BADF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
